// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter with open-drain enables.
// Define PS2_TX_RETRY_EN to resend a NACKed or timed-out byte up to twice.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error
);

  localparam int HALF = FILTER_LEN / 2;
  localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                        INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      byte_q, byte_d;
  logic            par_q, par_d;
  logic            dat_q, dat_d;
  logic            ack_q, ack_d;
  logic            ok_q, ok_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            can_retry;
  logic            bit_v;

  logic [1:0]            clk_sy, dat_sy;
  logic [FILTER_LEN-1:0] filt;
  logic                  clk_s, data_s, fall;

  // Bus idles high, so synchronizers and filter reset to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sy <= 2'b11;
      dat_sy <= 2'b11;
      filt   <= '1;
    end else begin
      clk_sy <= {clk_sy[0], ps2_clk_in};
      dat_sy <= {dat_sy[0], ps2_data_in};
      filt   <= {filt[FILTER_LEN-2:0], clk_sy[1]};
    end
  end

  assign clk_s  = clk_sy[1];
  assign data_s = dat_sy[1];
  assign fall   = (&filt[FILTER_LEN-1:HALF]) & ~(|filt[HALF-1:0]);

  always_comb begin
    bit_v = 1'b1;
    if (idx_q < 4'd8) bit_v = byte_q[idx_q[2:0]];
    else if (idx_q == 4'd8) bit_v = par_q;
  end

`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_q, retry_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) retry_q <= 2'd0;
    else        retry_q <= retry_d;
  end
  assign can_retry = (retry_q != 2'd2);
`else
  assign can_retry = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    par_d   = par_q;
    dat_d   = dat_q;
    ack_d   = ack_q;
    ok_d    = ok_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      IDLE: begin
        dat_d = 1'b0;
        if (tx_valid) begin
          state_d = INHIBIT;
          cnt_d   = '0;
          byte_d  = tx_data;
          par_d   = ~^tx_data;
          ok_d    = 1'b0;
`ifdef PS2_TX_RETRY_EN
          retry_d = 2'd0;
`endif
        end
      end
      INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          state_d = REQ;
          cnt_d   = '0;
          dat_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REQ: begin
        state_d = SEND;
        idx_d   = 4'd0;
        cnt_d   = '0;
      end
      SEND, ACK, WAIT_IDLE: begin
        if (state_q == WAIT_IDLE && clk_s && data_s) begin
          cnt_d = '0;
          if (!ack_q && can_retry) begin
            state_d = INHIBIT;
`ifdef PS2_TX_RETRY_EN
            retry_d = retry_q + 2'd1;
`endif
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            ok_d    = ack_q;
          end
        end else if (fall) begin
          // A fall always wins over a coincident timeout.
          cnt_d = '0;
          if (state_q == SEND) begin
            idx_d = idx_q + 4'd1;
            dat_d = ~bit_v;
            if (idx_q == 4'd9) state_d = ACK;
          end else if (state_q == ACK) begin
            ack_d   = ~data_s;
            state_d = WAIT_IDLE;
          end
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          cnt_d = '0;
          dat_d = 1'b0;
          if (can_retry) begin
            state_d = INHIBIT;
`ifdef PS2_TX_RETRY_EN
            retry_d = retry_q + 2'd1;
`endif
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      byte_q  <= 8'd0;
      par_q   <= 1'b0;
      dat_q   <= 1'b0;
      ack_q   <= 1'b0;
      ok_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      par_q   <= par_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      ok_q    <= ok_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign tx_ready    = (state_q == IDLE);
  assign busy        = ~tx_ready;
  assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
  assign ps2_data_oe = dat_q;
  assign tx_done     = done_q;
  assign tx_ack_ok   = ok_q;
  assign tx_error    = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device.
// Expected frame bits are queued at request time and popped as the device samples.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int TO  = 400;
  localparam int FL  = 6;
  localparam int H   = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int NFR = 3;
`else
  localparam int NFR = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_ack_ok, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk = 1'b1, dev_data = 1'b1;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .tx_done(tx_done),
    .tx_ack_ok(tx_ack_ok),
    .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  int   n_vec = 0, n_err = 0;
  int   done_cnt = 0, err_cnt = 0;
  int   done_base = 0, err_base = 0;
  logic done_ok = 1'b0, done_busy = 1'b0;
  logic sb[$];

  always @(negedge clk) begin
    if (tx_done) begin
      done_cnt++;
      done_ok   = tx_ack_ok;
      done_busy = busy;
    end
    if (tx_error) err_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    done_base = done_cnt;
    err_base  = err_cnt;
    tx_data   = b;
    tx_valid  = 1'b1;
    chk("clk_oe_pre_accept", ps2_clk_oe, 0);
    chk("ready_idle", tx_ready, 1);
    @(posedge clk);
    #1;
    chk("clk_oe_post_accept", ps2_clk_oe, 1);
    chk("busy_post_accept", busy, 1);
    tx_valid = 1'b0;
    for (int f = 0; f < NFR; f++) begin
      for (int i = 0; i < 8; i++) sb.push_back(b[i]);
      sb.push_back(~^b);
      sb.push_back(1'b1);
    end
  endtask

  task automatic wait_req();
    int inh = 0, req = 0, n = 0;
    @(negedge clk);
    while (!ps2_clk_oe && n < 2000) begin
      @(negedge clk);
      n++;
    end
    while (ps2_clk_oe && n < 2000) begin
      if (ps2_data_oe) req++;
      else inh++;
      @(negedge clk);
      n++;
    end
    chk("req_in_time", int'(n < 2000), 1);
    chk("inhibit_len", inh, INH);
    chk("req_len", req, 1);
    chk("start_bit", ps2_data_oe, 1);
  endtask

  task automatic dev_clock(input logic nack, input int stop_k,
                           input int glitch_k, input int poke_k);
    for (int k = 1; k <= 11; k++) begin
      for (int c = 0; c < H; c++) begin
        @(negedge clk);
        if (c == H/2 && k >= 2) begin
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else chk($sformatf("bit%0d", k - 1), ps2_data_in, sb.pop_front());
        end
        if (k == 11 && c == H/2 + 1) dev_data = nack;
        if (k == glitch_k && c == 4) dev_clk = 1'b0;
        if (k == glitch_k && c == 6) dev_clk = 1'b1;
        if (k == poke_k && c == 2) begin
          tx_data  = 8'h55;
          tx_valid = 1'b1;
        end
        if (k == poke_k && c == 3) tx_valid = 1'b0;
      end
      dev_clk = 1'b0;
      if (k == stop_k) return;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
    end
    repeat (H/2) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input logic exp_ok);
    int n = 0;
    while (done_cnt == done_base && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done_cnt - done_base, 1);
    chk("ack_ok", done_ok, exp_ok);
    chk("busy_at_done", done_busy, 0);
    repeat (10) @(negedge clk);
    chk("done_once", done_cnt - done_base, 1);
    chk("idle_after", busy, 0);
    chk("no_error", err_cnt - err_base, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ack_ok", tx_ack_ok, 0);
    chk("rst_error", tx_error, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED, acked, with an ignored 0x55 request mid-frame
    start_tx(8'hED);
    wait_req();
    dev_clock(1'b0, 0, 0, 3);
    wait_done(1'b1);

    // 0xF4, device never acks
    start_tx(8'hF4);
    for (int f = 0; f < NFR; f++) begin
      wait_req();
      dev_clock(1'b1, 0, 0, 0);
    end
    wait_done(1'b0);

    // device stalls with clock low after fall 4
    start_tx(8'h3C);
    wait_req();
    dev_clock(1'b0, 4, 0, 0);
    n = 0;
    while (!tx_error && n < 4 * TO) begin
      @(negedge clk);
      n++;
    end
`ifdef PS2_TX_RETRY_EN
    chk("timeout_window", int'(n >= 3 * TO && n <= 3 * TO + 2 * (INH + 2) + 20), 1);
`else
    chk("timeout_window", int'(n >= TO && n <= TO + FL + 4), 1);
`endif
    chk("to_clk_oe", ps2_clk_oe, 0);
    chk("to_data_oe", ps2_data_oe, 0);
    chk("to_ready", tx_ready, 1);
    sb.delete();
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);
    chk("to_err_once", err_cnt - err_base, 1);
    chk("to_no_done", done_cnt - done_base, 0);

    // reset mid-frame after fall 6
    start_tx(8'h00);
    wait_req();
    dev_clock(1'b0, 6, 0, 0);
    repeat (8) @(negedge clk);
    chk("pre_reset_data_oe", ps2_data_oe, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_clk_oe", ps2_clk_oe, 0);
    chk("mid_rst_data_oe", ps2_data_oe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_ack_ok", tx_ack_ok, 0);
    chk("mid_rst_error", tx_error, 0);
    sb.delete();
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    start_tx(8'hFF);
    wait_req();
    dev_clock(1'b0, 0, 0, 0);
    wait_done(1'b1);

    // 2-cycle clock glitch during the high phase before fall 5
    start_tx(8'hA6);
    wait_req();
    dev_clock(1'b0, 0, 5, 0);
    wait_done(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
